// File: rtl/map_pkg.sv
// -----------------------------------------------------------------------------
// map_pkg
// Shared definitions for the map loading path: map geometry, stream magic
// byte, spawn angle constants, the loader state encoding and a helper that
// turns the 2-bit spawn direction into degrees.
// Ports: none (package).
// -----------------------------------------------------------------------------
package map_pkg;

   localparam int MAP_W      = 8;              // map is MAP_W x MAP_W cells
   localparam int CELL_W     = 2;              // bits per cell
   localparam int MAP_CELLS  = 64;             // MAP_W * MAP_W
   localparam int ADDR_W     = 6;              // log2(MAP_CELLS)
   localparam int DATA_BYTES = 16;             // MAP_CELLS / cells-per-byte

   localparam logic [7:0] MAGIC = 8'hA5;

   localparam logic [8:0] ANGLE_0   = 9'd0;
   localparam logic [8:0] ANGLE_90  = 9'd90;
   localparam logic [8:0] ANGLE_180 = 9'd180;
   localparam logic [8:0] ANGLE_270 = 9'd270;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_MAGIC  = 3'd1,
      S_SPAWN  = 3'd2,
      S_DATA   = 3'd3,
      S_UNPACK = 3'd4,
      S_CSUM   = 3'd5,
      S_DONE   = 3'd6,
      S_ERR    = 3'd7
   } loader_state_t;

   function automatic logic [8:0] dir_to_angle(input logic [1:0] dir);
      logic [8:0] angle;
      case (dir)
         2'd0:    angle = ANGLE_0;
         2'd1:    angle = ANGLE_90;
         2'd2:    angle = ANGLE_180;
         default: angle = ANGLE_270;
      endcase
      return angle;
   endfunction

endpackage

// File: rtl/map_loader_if.sv
// -----------------------------------------------------------------------------
// map_loader_if
// Byte stream channel feeding the map loader.
// Handshake: the source drives in_data/in_valid, the loader drives in_ready.
// A byte transfers on a rising clk edge where in_valid && in_ready are both 1.
// in_ready depends only on loader state, never on in_valid, so the source may
// raise or drop in_valid in any cycle; a low in_valid simply stalls.
// Signals:
//   in_data  [7:0] stream byte            (master -> slave)
//   in_valid       in_data is meaningful  (master -> slave)
//   in_ready       loader accepts a byte  (slave  -> master)
// -----------------------------------------------------------------------------
interface map_loader_if;

   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/map_ram.sv
// -----------------------------------------------------------------------------
// map_ram
// 64 x 2-bit map storage: synchronous write, asynchronous read. Not reset, so
// the map survives a loader reset.
// Ports:
//   clk        system clock
//   i_wr_en    write strobe
//   i_wr_addr  write cell address (y*8 + x)
//   i_wr_data  cell value
//   i_rd_addr  read cell address
//   o_rd_data  cell value at i_rd_addr (combinational)
// -----------------------------------------------------------------------------
module map_ram
   import map_pkg::*;
(
   input  logic              clk,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [CELL_W-1:0] i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [CELL_W-1:0] o_rd_data
);

   logic [CELL_W-1:0] r_mem [MAP_CELLS];

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/map_loader.sv
// -----------------------------------------------------------------------------
// map_loader
// Parses a 19-byte level stream (magic, spawn pose, 16 packed map bytes,
// XOR checksum), unpacks each map byte into four consecutive map RAM writes
// and publishes the spawn pose only when the whole load is clean. The map RAM
// sits alongside the loader here and exposes a read port for map readers.
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   start           level; begins a load from IDLE/DONE/ERR
//   s_in            byte stream (in_data/in_valid in, in_ready out)
//   wr_en/addr/data map RAM write port (also visible to outside observers)
//   spawn_x/y/angle committed player spawn pose
//   busy/done/error load status levels
//   rd_addr/rd_data map RAM read port
//   dbg_state       current loader state
// -----------------------------------------------------------------------------
module map_loader
   import map_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   map_loader_if.slave       s_in,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [CELL_W-1:0] wr_data,
   output logic [2:0]        spawn_x,
   output logic [2:0]        spawn_y,
   output logic [8:0]        spawn_angle,
   output logic              busy,
   output logic              done,
   output logic              error,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [CELL_W-1:0] rd_data,
   output loader_state_t     dbg_state
);

   loader_state_t r_state;
   loader_state_t w_next;

   logic [7:0]        r_byte;        // map byte being unpacked
   logic [1:0]        r_k;           // cell index within r_byte
   logic [3:0]        r_byte_cnt;    // map byte index 0..15
   logic [ADDR_W-1:0] r_addr;        // next cell address
   logic [7:0]        r_csum;        // running XOR of bytes 1..17
   logic              r_wall;        // spawn cell written non-zero
   logic [2:0]        r_pend_x;
   logic [2:0]        r_pend_y;
   logic [1:0]        r_pend_dir;
   logic [2:0]        r_spawn_x;
   logic [2:0]        r_spawn_y;
   logic [8:0]        r_spawn_angle;

   logic              w_in_ready;
   logic              w_accept;
   logic              w_last_cell;
   logic              w_load_ok;
   logic [CELL_W-1:0] w_cell;

   assign w_accept    = w_in_ready && s_in.in_valid;
   assign w_cell      = r_byte[{r_k, 1'b0} +: CELL_W];
   assign w_last_cell = (r_k == 2'd3);
   assign w_load_ok   = (s_in.in_data == r_csum) && !r_wall;

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ---------------- next state and status outputs ----------------
   always_comb begin
      w_next     = r_state;
      w_in_ready = 1'b0;
      wr_en      = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      case (r_state)
         S_IDLE, S_DONE, S_ERR: begin
            done  = (r_state == S_DONE);
            error = (r_state == S_ERR);
            if (start) begin
               w_next = S_MAGIC;
            end
         end
         S_MAGIC: begin
            w_in_ready = 1'b1;
            busy       = 1'b1;
            if (s_in.in_valid) begin
               w_next = (s_in.in_data == MAGIC) ? S_SPAWN : S_ERR;
            end
         end
         S_SPAWN: begin
            w_in_ready = 1'b1;
            busy       = 1'b1;
            if (s_in.in_valid) begin
               w_next = S_DATA;
            end
         end
         S_DATA: begin
            w_in_ready = 1'b1;
            busy       = 1'b1;
            if (s_in.in_valid) begin
               w_next = S_UNPACK;
            end
         end
         S_UNPACK: begin
            wr_en = 1'b1;
            busy  = 1'b1;
            if (w_last_cell) begin
               w_next = (r_byte_cnt == 4'(DATA_BYTES - 1)) ? S_CSUM : S_DATA;
            end
         end
         S_CSUM: begin
            w_in_ready = 1'b1;
            busy       = 1'b1;
            if (s_in.in_valid) begin
               w_next = w_load_ok ? S_DONE : S_ERR;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_byte        <= '0;
         r_k           <= '0;
         r_byte_cnt    <= '0;
         r_addr        <= '0;
         r_csum        <= '0;
         r_wall        <= 1'b0;
         r_pend_x      <= '0;
         r_pend_y      <= '0;
         r_pend_dir    <= '0;
         r_spawn_x     <= '0;
         r_spawn_y     <= '0;
         r_spawn_angle <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  r_k        <= '0;
                  r_byte_cnt <= '0;
                  r_addr     <= '0;
                  r_csum     <= '0;
                  r_wall     <= 1'b0;
               end
            end
            S_SPAWN: begin
               if (w_accept) begin
                  // Held as pending until the checksum confirms the stream.
                  r_pend_x   <= s_in.in_data[2:0];
                  r_pend_y   <= s_in.in_data[5:3];
                  r_pend_dir <= s_in.in_data[7:6];
                  r_csum     <= r_csum ^ s_in.in_data;
               end
            end
            S_DATA: begin
               if (w_accept) begin
                  r_byte <= s_in.in_data;
                  r_csum <= r_csum ^ s_in.in_data;
               end
            end
            S_UNPACK: begin
               r_k <= r_k + 2'd1;
               // Hold at the last cell rather than wrap back to 0.
               if (r_addr != ADDR_W'(MAP_CELLS - 1)) begin
                  r_addr <= r_addr + 1'b1;
               end
               if (w_last_cell) begin
                  r_byte_cnt <= r_byte_cnt + 4'd1;
               end
               // {y, x} is exactly y*8 + x for an 8-wide map.
               if ((r_addr == {r_pend_y, r_pend_x}) && (w_cell != '0)) begin
                  r_wall <= 1'b1;
               end
            end
            S_CSUM: begin
               if (w_accept && w_load_ok) begin
                  r_spawn_x     <= r_pend_x;
                  r_spawn_y     <= r_pend_y;
                  r_spawn_angle <= dir_to_angle(r_pend_dir);
               end
            end
            default: ;
         endcase
      end
   end

   assign s_in.in_ready = w_in_ready;
   assign wr_addr       = r_addr;
   assign wr_data       = w_cell;
   assign spawn_x       = r_spawn_x;
   assign spawn_y       = r_spawn_y;
   assign spawn_angle   = r_spawn_angle;
   assign dbg_state     = r_state;

   map_ram u_ram (
      .clk       (clk),
      .i_wr_en   (wr_en),
      .i_wr_addr (r_addr),
      .i_wr_data (w_cell),
      .i_rd_addr (rd_addr),
      .o_rd_data (rd_data)
   );

endmodule

// File: tb/tb_map_loader.sv
module tb_map_loader;
   import map_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   logic start;
   always #5 clk = ~clk;

   logic       wr_en;
   logic [5:0] wr_addr;
   logic [1:0] wr_data;
   logic [2:0] spawn_x;
   logic [2:0] spawn_y;
   logic [8:0] spawn_angle;
   logic       busy;
   logic       done;
   logic       error;
   logic [5:0] rd_addr;
   logic [1:0] rd_data;
   loader_state_t dbg_state;

   map_loader_if u_if ();

   map_loader dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .s_in        (u_if),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .spawn_x     (spawn_x),
      .spawn_y     (spawn_y),
      .spawn_angle (spawn_angle),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .dbg_state   (dbg_state)
   );

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;
   int wr_count = 0;
   logic [7:0] exp_q[$];            // expected {addr, data} writes in order

   logic [1:0] cells [64];          // reference map for the current load
   logic [7:0] stream [19];         // bytes sent for the current load
   logic [2:0] m_x;
   logic [2:0] m_y;
   logic [8:0] m_ang;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard on the write port ----------------
   always @(negedge clk) begin
      logic [7:0] e;
      if (wr_en === 1'b1) begin
         wr_count++;
         check("ready_during_write", u_if.in_ready, 0);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write got addr=%0d data=%0d want none", wr_addr, wr_data);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("write[%0d]", e[7:2]), {wr_addr, wr_data}, e);
         end
      end
   end

   // ---------------- reference model ----------------
   task automatic build_map(input int kind);
      for (int i = 0; i < 64; i++) begin
         int x = i % 8;
         int y = i / 8;
         logic border = (x == 0) || (x == 7) || (y == 0) || (y == 7);
         case (kind)
            0:       cells[i] = border ? 2'd1 : 2'd0;
            1:       cells[i] = (border || i == 26) ? 2'd1 : 2'd0;
            default: cells[i] = 2'd0;
         endcase
      end
   endtask

   task automatic build_stream(input logic [7:0] magic, input logic [7:0] spawn, input logic [7:0] csum_xor);
      logic [7:0] x;
      stream[0] = magic;
      stream[1] = spawn;
      for (int n = 0; n < 16; n++) begin
         int v = 0;
         for (int k = 0; k < 4; k++) v += int'(cells[4*n+k]) * (4 ** k);
         stream[2+n] = 8'(v);
      end
      x = 8'h00;
      for (int b = 1; b <= 17; b++) x ^= stream[b];
      stream[18] = x ^ csum_xor;
   endtask

   task automatic push_all_writes();
      for (int a = 0; a < 64; a++) exp_q.push_back({6'(a), cells[a]});
   endtask

   // ---------------- driver ----------------
   task automatic drive_bytes(input string tag, input int n, input int pct, input bit noise, input int exp_sent);
      int idx = 0;
      int cyc = 0;
      while (idx < n && cyc < 3000) begin
         @(negedge clk);
         if (busy !== 1'b1 && idx > 0) break;
         start = (noise && idx >= 2 && idx < n - 1) ? 1'($urandom_range(1)) : 1'b0;
         u_if.in_valid = ($urandom_range(99) < pct);
         u_if.in_data  = stream[idx];
         if (u_if.in_valid && u_if.in_ready === 1'b1) idx++;
         cyc++;
      end
      @(negedge clk);
      u_if.in_valid = 1'b0;
      start = 1'b0;
      check({tag, ":bytes_accepted"}, idx, exp_sent);
   endtask

   task automatic run_load(input string tag, input logic [7:0] magic, input logic [7:0] spawn,
                           input logic [7:0] csum_xor, input int pct, input bit noise,
                           input logic e_done, input logic e_error, input int e_writes,
                           input logic [2:0] ex, input logic [2:0] ey, input logic [8:0] eang);
      wr_count = 0;
      exp_q.delete();
      build_stream(magic, spawn, csum_xor);
      if (magic == MAGIC) push_all_writes();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, ":busy_after_start"}, busy, 1);
      check({tag, ":done_cleared"}, done, 0);
      drive_bytes(tag, 19, pct, noise, (magic == MAGIC) ? 19 : 1);
      for (int t = 0; t < 20 && busy !== 1'b0; t++) @(negedge clk);
      check({tag, ":busy"}, busy, 0);
      check({tag, ":done"}, done, e_done);
      check({tag, ":error"}, error, e_error);
      check({tag, ":spawn_x"}, spawn_x, ex);
      check({tag, ":spawn_y"}, spawn_y, ey);
      check({tag, ":spawn_angle"}, spawn_angle, eang);
      check({tag, ":write_count"}, wr_count, e_writes);
      check({tag, ":writes_left"}, exp_q.size(), 0);
      if (e_writes == 64) begin
         for (int a = 0; a < 64; a++) begin
            @(negedge clk);
            rd_addr = 6'(a);
            #1;
            check($sformatf("%s:ram[%0d]", tag, a), rd_data, cells[a]);
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ":wr_en"}, wr_en, 0);
      check({tag, ":wr_addr"}, wr_addr, 0);
      check({tag, ":wr_data"}, wr_data, 0);
      check({tag, ":in_ready"}, u_if.in_ready, 0);
      check({tag, ":busy"}, busy, 0);
      check({tag, ":done"}, done, 0);
      check({tag, ":error"}, error, 0);
      check({tag, ":spawn_x"}, spawn_x, 0);
      check({tag, ":spawn_y"}, spawn_y, 0);
      check({tag, ":spawn_angle"}, spawn_angle, 0);
      check({tag, ":state"}, dbg_state, S_IDLE);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0] magic;
      logic [7:0] spawn;
      int         map_kind;   // 0 border, 1 border + cell 26, 2 empty
      logic [7:0] csum_xor;
      int         pct;        // in_valid duty in percent
      bit         noise;      // toggle start while busy
      logic       exp_done;
      logic       exp_error;
      int         exp_writes;
      logic [2:0] exp_x;
      logic [2:0] exp_y;
      logic [8:0] exp_angle;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      start = 1'b0;
      u_if.in_valid = 1'b0;
      u_if.in_data = 8'h00;
      rd_addr = 6'd0;

      vecs[0] = '{8'hA5, 8'h49, 0, 8'h00, 100, 1'b0, 1'b1, 1'b0, 64, 3'd1, 3'd1, 9'd90};
      vecs[1] = '{8'h5A, 8'h49, 0, 8'h00, 100, 1'b0, 1'b0, 1'b1,  0, 3'd1, 3'd1, 9'd90};
      vecs[2] = '{8'hA5, 8'hD2, 0, 8'h01, 100, 1'b0, 1'b0, 1'b1, 64, 3'd1, 3'd1, 9'd90};
      vecs[3] = '{8'hA5, 8'h1A, 1, 8'h00, 100, 1'b0, 1'b0, 1'b1, 64, 3'd1, 3'd1, 9'd90};
      vecs[4] = '{8'hA5, 8'h80, 0, 8'h00, 100, 1'b0, 1'b0, 1'b1, 64, 3'd1, 3'd1, 9'd90};
      vecs[5] = '{8'hA5, 8'hBF, 2, 8'h00,  60, 1'b1, 1'b1, 1'b0, 64, 3'd7, 3'd7, 9'd180};
      vecs[6] = '{8'hA5, 8'hD2, 0, 8'h00, 100, 1'b0, 1'b1, 1'b0, 64, 3'd2, 3'd2, 9'd270};
      vecs[7] = '{8'hA5, 8'h49, 0, 8'h00,  30, 1'b1, 1'b1, 1'b0, 64, 3'd1, 3'd1, 9'd90};

      #1;
      check_reset_outputs("reset");
      repeat (3) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         build_map(vecs[i].map_kind);
         run_load($sformatf("vec%0d", i), vecs[i].magic, vecs[i].spawn, vecs[i].csum_xor,
                  vecs[i].pct, vecs[i].noise, vecs[i].exp_done, vecs[i].exp_error,
                  vecs[i].exp_writes, vecs[i].exp_x, vecs[i].exp_y, vecs[i].exp_angle);
      end

      // Reset while the 7th map byte (cells 24..27) is being unpacked.
      build_map(0);
      build_stream(8'hA5, 8'h49, 8'h00);
      wr_count = 0;
      exp_q.delete();
      push_all_writes();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drive_bytes("midrst", 9, 100, 1'b0, 9);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("midrst:write_count", wr_count, 26);
      check("midrst:state_idle", dbg_state, S_IDLE);
      rd_addr = 6'd0;
      #1;
      check("midrst:ram_kept", rd_data, 1);
      run_load("after_rst", 8'hA5, 8'h49, 8'h00, 100, 1'b0, 1'b1, 1'b0, 64, 3'd1, 3'd1, 9'd90);
      m_x = 3'd1;
      m_y = 3'd1;
      m_ang = 9'd90;

      // Randomized loads judged by the reference rules.
      for (int r = 0; r < 6; r++) begin
         logic [7:0] sp;
         logic [7:0] mg;
         logic [7:0] cx;
         int pct;
         int sidx;
         bit ok;
         for (int i = 0; i < 64; i++)
            cells[i] = ($urandom_range(3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         sp   = 8'($urandom);
         mg   = ($urandom_range(9) == 0) ? 8'h5A : 8'hA5;
         cx   = ($urandom_range(4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         pct  = $urandom_range(20, 100);
         sidx = int'(sp[5:3]) * 8 + int'(sp[2:0]);
         ok   = (mg == 8'hA5) && (cx == 8'h00) && (cells[sidx] == 2'd0);
         if (ok) begin
            m_x   = sp[2:0];
            m_y   = sp[5:3];
            m_ang = 9'(int'(sp[7:6]) * 90);
         end
         run_load($sformatf("rnd%0d", r), mg, sp, cx, pct, 1'b1, ok, !ok,
                  (mg == 8'hA5) ? 64 : 0, m_x, m_y, m_ang);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
